// File: rtl/ahb2apb_ahb_slv_if_pkg.sv
// +--------------------------------------------------------------------------+
// | ahb2apb_pkg : shared FSM states and AHB constants for the AHB slave side |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ahb2apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DATA     = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERR1     = 3'd4,
      ST_ERR2     = 3'd5
   } ahb_slv_state_e;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Anything wider than a word cannot be carried by the APB side.
   function automatic logic size_ok(input logic [2:0] hsize);
      return (hsize <= HSIZE_WORD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb2apb_ahb_slv_if_if.sv
// +--------------------------------------------------------------------------+
// | ahb2apb_ahb_slv_if_if : AHB slave-port signal bundle                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ahb2apb_ahb_slv_if_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              hsel_i;
   logic [1:0]        htrans_i;
   logic              hwrite_i;
   logic [ADDR_W-1:0] haddr_i;
   logic [2:0]        hsize_i;
   logic [DATA_W-1:0] hwdata_i;
   logic              hready_i;
   logic              hreadyout_o;
   logic              hresp_o;
   logic [DATA_W-1:0] hrdata_o;

   modport slave (
      input  hsel_i, htrans_i, hwrite_i, haddr_i, hsize_i, hwdata_i, hready_i,
      output hreadyout_o, hresp_o, hrdata_o
   );

   modport master (
      output hsel_i, htrans_i, hwrite_i, haddr_i, hsize_i, hwdata_i, hready_i,
      input  hreadyout_o, hresp_o, hrdata_o
   );
endinterface

`default_nettype wire

// File: rtl/ahb2apb_ahb_slv_if.sv
// +--------------------------------------------------------------------------+
// | ahb2apb_ahb_slv_if : AHB slave front end, one unposted transfer at a time|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ahb2apb_ahb_slv_if
   import ahb2apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CMD_W  = 1 + ADDR_W + DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   ahb2apb_ahb_slv_if_if.slave ahb,
   output logic                wfifo_o,
   input  logic                wfull_i,
   output logic [CMD_W-1:0]    cmd_o,
   input  logic                rsp_empty_i,
   input  logic [DATA_W-1:0]   rsp_data_i,
   input  logic                rsp_err_i,
   output logic                rsp_rd_o
);

   ahb_slv_state_e    state_q;
   logic              hready_q;
   logic              hresp_q;
   logic [DATA_W-1:0] hrdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;

   logic              w_accept;
   logic [DATA_W-1:0] w_wdata;
   logic              w_unused;

   assign w_accept = ahb.hsel_i & ahb.htrans_i[1] & ahb.hready_i;
   assign w_unused = ahb.htrans_i[0];
   assign w_wdata  = wr_q ? ahb.hwdata_i : '0;

   // FIFO strobes are gated by rst so a reset cycle never touches either FIFO.
   assign wfifo_o  = (state_q == ST_DATA)     & ~wfull_i    & ~rst;
   assign rsp_rd_o = (state_q == ST_WAIT_RSP) & ~rsp_empty_i & ~rst;
   assign cmd_o    = CMD_W'({wr_q, addr_q, w_wdata});

   assign ahb.hreadyout_o = hready_q;
   assign ahb.hresp_o     = hresp_q;
   assign ahb.hrdata_o    = hrdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
         hrdata_q <= '0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  addr_q   <= ahb.haddr_i;
                  wr_q     <= ahb.hwrite_i;
                  hready_q <= 1'b0;
                  if (size_ok(ahb.hsize_i)) begin
                     state_q <= ST_DATA;
                     hresp_q <= 1'b0;
                  end else begin
                     state_q <= ST_ERR1;
                     hresp_q <= 1'b1;
                  end
               end else begin
                  state_q  <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= 1'b0;
               end
            end
            ST_DATA: begin
               if (!wfull_i) begin
                  state_q <= ST_WAIT_RSP;
               end
            end
            ST_WAIT_RSP: begin
               if (!rsp_empty_i) begin
                  if (!wr_q) begin
                     hrdata_q <= rsp_data_i;
                  end
                  if (rsp_err_i) begin
                     state_q <= ST_ERR1;
                     hresp_q <= 1'b1;
                  end else begin
                     state_q  <= ST_DONE;
                     hready_q <= 1'b1;
                     hresp_q  <= 1'b0;
                  end
               end
            end
            ST_ERR1: begin
               state_q  <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= 1'b1;
            end
            ST_ERR2: begin
               // Second ERROR cycle: whatever the master presents now is dropped.
               state_q  <= ST_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
            end
            default: begin
               state_q  <= ST_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_ahb_slv_if.sv
// +--------------------------------------------------------------------------+
// | tb_ahb2apb_ahb_slv_if : directed self-checking bench with cmd scoreboard |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ahb2apb_ahb_slv_if;

   logic        clk;
   logic        rst;
   logic        wfifo_o;
   logic        wfull_i;
   logic [64:0] cmd_o;
   logic        rsp_empty_i;
   logic [31:0] rsp_data_i;
   logic        rsp_err_i;
   logic        rsp_rd_o;

   int          n_tests;
   int          n_fail;
   int          wcnt;
   int          rcnt;
   logic [31:0] exp_hrdata;
   logic [64:0] sb_q[$];
   logic [3:0]  nq_tab [3] = '{4'b0101, 4'b1011, 4'b1100};

   ahb2apb_ahb_slv_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ahb2apb_ahb_slv_if #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ahb         (bus.slave),
      .wfifo_o     (wfifo_o),
      .wfull_i     (wfull_i),
      .cmd_o       (cmd_o),
      .rsp_empty_i (rsp_empty_i),
      .rsp_data_i  (rsp_data_i),
      .rsp_err_i   (rsp_err_i),
      .rsp_rd_o    (rsp_rd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Write-controller side: every push is checked against the scoreboard.
   always @(negedge clk) begin
      if (wfifo_o === 1'b1) begin
         wcnt++;
         if (sb_q.size() > 0) chk("cmd_o", 128'(cmd_o), 128'(sb_q.pop_front()));
         else chk("sb_occupancy_at_push", 128'(sb_q.size()), 128'(1));
      end
      if (rsp_rd_o === 1'b1) rcnt++;
   end

   task automatic idle(input int n);
      bus.hsel_i   = 1'b0;
      bus.htrans_i = 2'b00;
      repeat (n) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("idle_hready", 128'(bus.hreadyout_o), 128'(1));
         chk("idle_hresp", 128'(bus.hresp_o), 128'(0));
      end
   endtask

   // Drives one transfer from its address phase; returns mid-cycle in DONE/IDLE.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input int full_cyc, input int rsp_dly,
                       input bit err, input logic [31:0] rdata, input bit poke_err2);
      int w0 = wcnt;
      int r0 = rcnt;
      bus.hsel_i   = 1'b1;
      bus.htrans_i = 2'b10;
      bus.hwrite_i = wr;
      bus.haddr_i  = addr;
      bus.hsize_i  = size;
      bus.hwdata_i = $urandom;
      if (size <= 3'b010) sb_q.push_back({wr, addr, (wr ? wdata : 32'h0)});
      @(posedge clk); #1;
      bus.hsel_i   = 1'b0;
      bus.htrans_i = 2'b00;
      bus.hwrite_i = ~wr;
      bus.haddr_i  = $urandom;
      bus.hsize_i  = 3'b000;
      bus.hwdata_i = wdata;
      if (size > 3'b010) begin
         @(negedge clk);
         chk("size_err1_hready", 128'(bus.hreadyout_o), 128'(0));
         chk("size_err1_hresp", 128'(bus.hresp_o), 128'(1));
         @(posedge clk); #1;
         if (poke_err2) begin
            bus.hsel_i   = 1'b1;
            bus.htrans_i = 2'b10;
            bus.hwrite_i = 1'b1;
            bus.hsize_i  = 3'b010;
         end
         @(negedge clk);
         chk("size_err2_hready", 128'(bus.hreadyout_o), 128'(1));
         chk("size_err2_hresp", 128'(bus.hresp_o), 128'(1));
         @(posedge clk); #1;
         bus.hsel_i   = 1'b0;
         bus.htrans_i = 2'b00;
         @(negedge clk);
         chk("after_err_hready", 128'(bus.hreadyout_o), 128'(1));
         chk("after_err_hresp", 128'(bus.hresp_o), 128'(0));
         chk("size_err_pushes", 128'(wcnt - w0), 128'(0));
         chk("size_err_pops", 128'(rcnt - r0), 128'(0));
      end else begin
         for (int k = 0; k < full_cyc; k++) begin
            wfull_i = 1'b1;
            @(negedge clk);
            chk("full_wfifo", 128'(wfifo_o), 128'(0));
            chk("full_hready", 128'(bus.hreadyout_o), 128'(0));
            @(posedge clk); #1;
         end
         wfull_i = 1'b0;
         @(negedge clk);
         chk("push_wfifo", 128'(wfifo_o), 128'(1));
         chk("data_hready", 128'(bus.hreadyout_o), 128'(0));
         @(posedge clk); #1;
         bus.hwdata_i = $urandom;
         for (int k = 0; k < rsp_dly; k++) begin
            rsp_empty_i = 1'b1;
            @(negedge clk);
            chk("wait_rsp_rd", 128'(rsp_rd_o), 128'(0));
            chk("wait_hready", 128'(bus.hreadyout_o), 128'(0));
            @(posedge clk); #1;
         end
         rsp_empty_i = 1'b0;
         rsp_data_i  = rdata;
         rsp_err_i   = err;
         @(negedge clk);
         chk("pop_rsp_rd", 128'(rsp_rd_o), 128'(1));
         chk("pop_hready", 128'(bus.hreadyout_o), 128'(0));
         if (!wr) exp_hrdata = rdata;
         @(posedge clk); #1;
         rsp_empty_i = 1'b1;
         rsp_err_i   = 1'b0;
         rsp_data_i  = $urandom;
         if (err) begin
            @(negedge clk);
            chk("rsp_err1_hready", 128'(bus.hreadyout_o), 128'(0));
            chk("rsp_err1_hresp", 128'(bus.hresp_o), 128'(1));
            @(posedge clk); #1;
            @(negedge clk);
            chk("rsp_err2_hready", 128'(bus.hreadyout_o), 128'(1));
            chk("rsp_err2_hresp", 128'(bus.hresp_o), 128'(1));
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk("done_hready", 128'(bus.hreadyout_o), 128'(1));
         chk("done_hresp", 128'(bus.hresp_o), 128'(0));
         chk("hrdata", 128'(bus.hrdata_o), 128'(exp_hrdata));
         chk("xfer_pushes", 128'(wcnt - w0), 128'(1));
         chk("xfer_pops", 128'(rcnt - r0), 128'(1));
      end
   endtask

   initial begin
      int w0;
      int r0;
      n_tests      = 0;
      n_fail       = 0;
      wcnt         = 0;
      rcnt         = 0;
      exp_hrdata   = 32'h0;
      rst          = 1'b1;
      wfull_i      = 1'b0;
      rsp_empty_i  = 1'b1;
      rsp_data_i   = 32'h0;
      rsp_err_i    = 1'b0;
      bus.hsel_i   = 1'b0;
      bus.htrans_i = 2'b00;
      bus.hwrite_i = 1'b0;
      bus.haddr_i  = 32'h0;
      bus.hsize_i  = 3'b010;
      bus.hwdata_i = 32'h0;
      bus.hready_i = 1'b1;

      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rst_hready", 128'(bus.hreadyout_o), 128'(1));
      chk("rst_hresp", 128'(bus.hresp_o), 128'(0));
      chk("rst_hrdata", 128'(bus.hrdata_o), 128'(0));
      chk("rst_cmd", 128'(cmd_o), 128'(0));
      chk("rst_wfifo", 128'(wfifo_o), 128'(0));
      chk("rst_rsp_rd", 128'(rsp_rd_o), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      xfer(1'b1, 32'h0000_1000, 3'b010, 32'hCAFE_F00D, 0, 0, 1'b0, 32'h1111_2222, 1'b0);
      idle(1);
      xfer(1'b0, 32'h0000_2004, 3'b010, 32'hDEAD_BEEF, 0, 5, 1'b0, 32'h1234_5678, 1'b0);
      idle(1);
      xfer(1'b1, 32'h0000_2008, 3'b010, 32'hA5A5_0F0F, 4, 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
      idle(1);
      xfer(1'b0, 32'h0000_300C, 3'b010, 32'h0, 0, 2, 1'b1, 32'hBAD0_BAD0, 1'b0);
      idle(1);
      xfer(1'b1, 32'h0000_4000, 3'b011, 32'h1357_9BDF, 0, 0, 1'b0, 32'h0, 1'b1);
      xfer(1'b0, 32'h0000_4004, 3'b100, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
      idle(1);
      xfer(1'b1, 32'h0000_4008, 3'b000, 32'h0000_00EE, 0, 0, 1'b0, 32'h0, 1'b0);
      idle(1);

      // hsel / htrans / hready combinations that must not start a transfer.
      for (int i = 0; i < 3; i++) begin
         w0 = wcnt;
         bus.hsel_i   = nq_tab[i][3];
         bus.htrans_i = nq_tab[i][2:1];
         bus.hready_i = nq_tab[i][0];
         bus.hsize_i  = 3'b010;
         @(posedge clk); #1;
         bus.hsel_i   = 1'b0;
         bus.htrans_i = 2'b00;
         bus.hready_i = 1'b1;
         @(negedge clk);
         chk("noacc_hready", 128'(bus.hreadyout_o), 128'(1));
         @(posedge clk); #1;
         @(negedge clk);
         chk("noacc_pushes", 128'(wcnt - w0), 128'(0));
      end

      xfer(1'b1, 32'h0000_5000, 3'b010, 32'h0102_0304, 0, 0, 1'b0, 32'h0, 1'b0);
      xfer(1'b0, 32'h0000_5004, 3'b010, 32'h0, 0, 1, 1'b0, 32'h8765_4321, 1'b0);
      xfer(1'b1, 32'h0000_5008, 3'b001, 32'h0000_BEEF, 1, 0, 1'b0, 32'h0, 1'b0);

      // Reset while waiting for a response that is already available.
      r0 = rcnt;
      w0 = wcnt;
      bus.hsel_i   = 1'b1;
      bus.htrans_i = 2'b10;
      bus.hwrite_i = 1'b0;
      bus.haddr_i  = 32'h0000_6000;
      bus.hsize_i  = 3'b010;
      sb_q.push_back({1'b0, 32'h0000_6000, 32'h0});
      @(posedge clk); #1;
      bus.hsel_i   = 1'b0;
      bus.htrans_i = 2'b00;
      bus.hwdata_i = 32'h7777_7777;
      @(posedge clk); #1;
      rsp_empty_i = 1'b0;
      rsp_data_i  = 32'h55AA_55AA;
      rst         = 1'b1;
      @(negedge clk);
      chk("rst_cycle_rsp_rd", 128'(rsp_rd_o), 128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_hready", 128'(bus.hreadyout_o), 128'(1));
      chk("midrst_hresp", 128'(bus.hresp_o), 128'(0));
      chk("midrst_hrdata", 128'(bus.hrdata_o), 128'(0));
      chk("midrst_cmd", 128'(cmd_o), 128'(0));
      chk("midrst_rsp_rd", 128'(rsp_rd_o), 128'(0));
      @(posedge clk); #1;
      rst         = 1'b0;
      rsp_empty_i = 1'b1;
      exp_hrdata  = 32'h0;
      @(negedge clk);
      chk("post_rst_hready", 128'(bus.hreadyout_o), 128'(1));
      chk("midrst_pops", 128'(rcnt - r0), 128'(0));
      chk("midrst_pushes", 128'(wcnt - w0), 128'(1));
      idle(2);

      xfer(1'b0, 32'h0000_7000, 3'b010, 32'h0, 0, 0, 1'b0, 32'hFEED_FACE, 1'b0);
      idle(1);
      chk("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ahb2apb_ahb_slv_if.md
AHB2APB_AHB_SLV_IF -- requirements
Module: ahb2apb_ahb_slv_if

Interface
REQ-001 Parameter ADDR_W, default 32, AHB/APB address width.
REQ-002 Parameter DATA_W, default 32, data width; HSIZE above word (3'b010) unsupported.
REQ-003 Parameter CMD_W, default 1+ADDR_W+DATA_W, command word width {write, addr, wdata}.
REQ-004 Clock is clk; reset is rst; one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  HCLK-domain clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 hsel_i  input  1  slave select.
REQ-008 htrans_i  input  2  AHB transfer type; only bit 1 (NONSEQ/SEQ) qualifies.
REQ-009 hwrite_i  input  1  1 = write.
REQ-010 haddr_i  input  ADDR_W  address-phase address.
REQ-011 hsize_i  input  3  transfer size.
REQ-012 hwdata_i  input  DATA_W  write data, data phase.
REQ-013 hready_i  input  1  bus HREADY.
REQ-014 hreadyout_o  output  1  slave ready, registered.
REQ-015 hresp_o  output  1  1 = ERROR, registered.
REQ-016 hrdata_o  output  DATA_W  read data, registered.
REQ-017 wfifo_o  output  1  command-FIFO write request to write controller.
REQ-018 wfull_i  input  1  command-FIFO full from write controller.
REQ-019 cmd_o  output  CMD_W  command word {hwrite, haddr, hwdata}.
REQ-020 rsp_empty_i  input  1  response-FIFO empty.
REQ-021 rsp_data_i  input  DATA_W  response read data.
REQ-022 rsp_err_i  input  1  response PSLVERR.
REQ-023 rsp_rd_o  output  1  response-FIFO pop, one cycle.

Function
REQ-024 FSM states IDLE, DATA, WAIT_RSP, DONE, ERR1, ERR2; one transfer outstanding, no posting.
REQ-025 Accept = hsel_i & htrans_i[1] & hready_i in IDLE or DONE; captures haddr_i, hwrite_i; next state DATA, or ERR1 if hsize_i > 3'b010.
REQ-026 IDLE/DONE without accept -> IDLE; hreadyout_o=1, hresp_o=0.
REQ-027 DATA: wfifo_o = ~wfull_i (combinational); cmd_o = {captured hwrite, captured haddr, hwdata_i (zero for reads)}; push -> WAIT_RSP; wfull_i=1 -> stay DATA, wfifo_o=0.
REQ-028 WAIT_RSP: rsp_rd_o = ~rsp_empty_i; on pop, latch rsp_data_i into hrdata_o (reads; writes leave hrdata_o unchanged); rsp_err_i=1 -> ERR1 else DONE.
REQ-029 hreadyout_o=0 in DATA, WAIT_RSP, ERR1; =1 in IDLE, DONE, ERR2.
REQ-030 ERR1: hresp_o=1, hreadyout_o=0; ERR2: hresp_o=1, hreadyout_o=1; ERR2 -> IDLE, transfer presented during ERR2 ignored.
REQ-031 Minimum latency: address phase at cycle 0 -> hreadyout_o=1 at cycle 3 (DATA, WAIT_RSP with response present, DONE).
REQ-032 At most one wfifo_o pulse and one rsp_rd_o pulse per transfer; none on unsupported-size error.

Reset
REQ-033 rst=1 at clk edge: state IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, captured address/write=0; wfifo_o=0, rsp_rd_o=0; reset mid-transfer abandons it without further FIFO access.

Structure
REQ-034 State enum and HSIZE_WORD constant SHALL live in shared package ahb2apb_pkg.
REQ-035 Single flat module; no sub-modules; instantiated beside ahb2apb_async_fifo_wrctrl in the HCLK domain.

Verification
REQ-036 Write 0x1000/0xCAFEF00D, FIFO empty -> one wfifo_o pulse, cmd_o={1,0x1000,0xCAFEF00D}; rsp ok -> hreadyout_o high cycle 3, hresp_o=0.
REQ-037 Read 0x2004, response 0x12345678 after 5 cycles -> hreadyout_o low until pop+1, hrdata_o=0x12345678, one rsp_rd_o.
REQ-038 wfull_i held 4 cycles in DATA -> no wfifo_o, hreadyout_o=0; push on first not-full cycle.
REQ-039 Response rsp_err_i=1 -> hresp_o=1/hreadyout_o=0 then hresp_o=1/hreadyout_o=1, then IDLE.
REQ-040 hsize_i=3'b011 -> two-cycle ERROR, no wfifo_o or rsp_rd_o pulse.
REQ-041 Back-to-back transfers accepted in DONE, plus rst asserted in WAIT_RSP -> outputs at reset values next cycle, no pop.
